// File: rtl/mem_fill_responder.sv
// mem_fill_responder
// Main-memory responder for the cache fill path. Accepts single-word reads and
// writes, and 8-word block-fill bursts. Read data comes back after a fixed
// pipelined latency (LATENCY cycles after acceptance), tagged with the
// word-aligned address, the word index within the block, and a last flag.
//
// Optional feature: define MEM_RESP_COUNT_EN to add the resp_count output, a
// saturating 16-bit count of data_valid cycles.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous, active-low reset (storage contents survive it)
//   req_valid   request present
//   req_ready   a request can be accepted this cycle (low while a burst issues)
//   req_we      1 = single-word write, 0 = read; ignored for bursts
//   req_burst   1 = 8-word fill of the block containing req_addr
//   req_addr    byte address, bit 0 ignored
//   req_wdata   write data
//   data_valid  data_out holds a read response this cycle
//   data_out    read response data
//   resp_addr   word-aligned byte address of the response
//   resp_word   word index within the block (resp_addr[3:1])
//   resp_last   final word of a burst; also set for single reads
//   resp_count  (MEM_RESP_COUNT_EN only) saturating count of responses
module mem_fill_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int DEPTH_LOG2  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [2:0]        resp_word,
  output logic              resp_last
`ifdef MEM_RESP_COUNT_EN
  ,
  output logic [15:0]       resp_count
`endif
);

  // Stages between the storage read and the output register.
  localparam int PIPE = LATENCY - 1;
  localparam logic [2:0] LAST_WC = 3'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] LSB_MASK = ~ADDR_W'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_reg;
  logic [2:0]             wc_reg;
  logic [ADDR_W-5:0]      base_reg;

  logic [DATA_W-1:0]      mem [0:(2**DEPTH_LOG2)-1];

  logic                   pipe_valid [1:PIPE];
  logic [ADDR_W-1:0]      pipe_addr  [1:PIPE];
  logic                   pipe_last  [1:PIPE];
  logic [DATA_W-1:0]      pipe_data  [1:PIPE];

  logic                   accept;
  logic                   burst_active;
  logic                   mem_write;
  logic                   issue_valid;
  logic                   issue_last;
  logic [ADDR_W-1:0]      req_addr_even;
  logic [ADDR_W-1:0]      issue_addr;

  assign burst_active  = (state_reg == BURST);
  assign accept        = req_valid && req_ready;
  assign mem_write     = accept && !req_burst && req_we;
  assign req_addr_even = req_addr & LSB_MASK;

  // One storage read is issued per cycle: burst words 1..7 while BURST, or the
  // accepted single read / burst word 0 otherwise. burst_active is checked
  // first so request inputs are don't-care during a burst.
  always_comb begin
    issue_valid = burst_active || (accept && (req_burst || !req_we));
    issue_addr  = req_addr_even;
    issue_last  = 1'b1;
    if (burst_active) begin
      issue_addr = {base_reg, wc_reg, 1'b0};
      issue_last = (wc_reg == LAST_WC);
    end else if (req_burst) begin
      issue_addr = {req_addr[ADDR_W-1:4], 4'h0};
      issue_last = 1'b0;
    end
  end

  // Burst sequencer. req_ready is registered: it drops the cycle after a
  // burst is accepted and rises again the cycle after word 7 is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      wc_reg    <= 3'd0;
      base_reg  <= '0;
      req_ready <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && req_burst) begin
            state_reg <= BURST;
            wc_reg    <= 3'd1;
            base_reg  <= req_addr[ADDR_W-1:4];
            req_ready <= 1'b0;
          end
        end
        BURST: begin
          if (wc_reg == LAST_WC) begin
            state_reg <= IDLE;
            wc_reg    <= 3'd0;
            req_ready <= 1'b1;
          end else begin
            wc_reg <= wc_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Storage and data path. No reset here so the array maps onto block RAM and
  // contents survive a reset; the first pipe_data stage is the RAM read
  // register. Writes and reads never share an edge (one request per cycle,
  // none accepted during a burst), so a read right after a write sees it.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[req_addr[DEPTH_LOG2:1]] <= req_wdata;
    end
    if (issue_valid) begin
      pipe_data[1] <= mem[issue_addr[DEPTH_LOG2:1]];
    end
    for (int i = 2; i <= PIPE; i++) begin
      if (pipe_valid[i-1]) begin
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Control side of the pipeline plus the output register. Reset drops every
  // in-flight entry, which is how a mid-burst reset discards pending words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= PIPE; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_addr[i]  <= '0;
        pipe_last[i]  <= 1'b0;
      end
      data_valid <= 1'b0;
      data_out   <= '0;
      resp_addr  <= '0;
      resp_word  <= 3'd0;
      resp_last  <= 1'b0;
    end else begin
      pipe_valid[1] <= issue_valid;
      if (issue_valid) begin
        pipe_addr[1] <= issue_addr;
        pipe_last[1] <= issue_last;
      end
      for (int i = 2; i <= PIPE; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_addr[i] <= pipe_addr[i-1];
          pipe_last[i] <= pipe_last[i-1];
        end
      end
      data_valid <= pipe_valid[PIPE];
      if (pipe_valid[PIPE]) begin
        data_out  <= pipe_data[PIPE];
        resp_addr <= pipe_addr[PIPE];
        resp_word <= pipe_addr[PIPE][3:1];
        resp_last <= pipe_last[PIPE];
      end
    end
  end

`ifdef MEM_RESP_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_count <= 16'd0;
    end else if (data_valid && (resp_count != 16'hFFFF)) begin
      resp_count <= resp_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder. A reference model (word array
// plus a queue of expected responses tagged with their due cycle) is compared
// against every response the DUT produces.
module tb_mem_fill_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        req_ready;
  logic        data_valid;
  logic [15:0] data_out;
  logic [15:0] resp_addr;
  logic [2:0]  resp_word;
  logic        resp_last;
`ifdef MEM_RESP_COUNT_EN
  logic [15:0] resp_count;
`endif

  mem_fill_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_burst  (req_burst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .data_valid (data_valid),
    .data_out   (data_out),
    .resp_addr  (resp_addr),
    .resp_word  (resp_word),
    .resp_last  (resp_last)
`ifdef MEM_RESP_COUNT_EN
    ,
    .resp_count (resp_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          c;
    logic [15:0] d;
    logic [15:0] a;
    logic [2:0]  w;
    logic        l;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       got_q[$];
  logic [15:0] mdl [int];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Advance one cycle; sample 1 ns after the edge and log any response.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid === 1'b1) begin
      got_q.push_back('{cyc, data_out, resp_addr, resp_word, resp_last});
      $display("cycle %0d resp addr=%h word=%0d last=%b data=%h",
               cyc, resp_addr, resp_word, resp_last, data_out);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    int k;
    k = int'(a[15:1]);
    return mdl.exists(k) ? mdl[k] : 16'hxxxx;
  endfunction

  // Reference behaviour of one request accepted at the edge ending cycle c.
  function automatic void model(input logic we, input logic burst,
                                input logic [15:0] addr, input logic [15:0] wd,
                                input int c);
    logic [15:0] a;
    if (burst) begin
      for (int k = 0; k < 8; k++) begin
        a = {addr[15:4], 4'(2 * k)};
        exp_q.push_back('{c + LAT + k, rd(a), a, 3'(k), (k == 7)});
      end
    end else if (we) begin
      mdl[int'(addr[15:1])] = wd;
    end else begin
      a = {addr[15:1], 1'b0};
      exp_q.push_back('{c + LAT, rd(a), a, addr[3:1], 1'b1});
    end
  endfunction

  // Present a request and hold it until accepted; leaves it driven afterwards
  // so the caller can chain back-to-back requests.
  task automatic issue(input logic we, input logic burst,
                       input logic [15:0] addr, input logic [15:0] wd);
    int guard = 0;
    req_valid = 1'b1; req_we = we; req_burst = burst;
    req_addr = addr; req_wdata = wd;
    while (req_ready !== 1'b1 && guard < 16) begin
      tick();
      guard++;
    end
    if (guard >= 16) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
    end else begin
      model(we, burst, addr, wd, cyc);
    end
    tick();
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'bx; req_burst = 1'bx;
    req_addr = 16'hxxxx; req_wdata = 16'hxxxx;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic fill(input logic [15:0] base, input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      issue(1'b1, 1'b0, base + 16'(2 * i), incr ? 16'(16'h1000 + i) : 16'($urandom));
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    drain(2);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b required 1", req_ready); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid got %b required 0", data_valid); end
    n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data_out got %h required 0000", data_out); end
    n_checks++; if (resp_addr !== 16'h0) begin n_fail++; $display("FAIL rst_resp_addr got %h required 0000", resp_addr); end
    n_checks++; if (resp_word !== 3'd0) begin n_fail++; $display("FAIL rst_resp_word got %0d required 0", resp_word); end
    n_checks++; if (resp_last !== 1'b0) begin n_fail++; $display("FAIL rst_resp_last got %b required 0", resp_last); end
    rst = 1'b1;
    drain(2);
    n_checks++; if (data_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst valid/ready got %b/%b required 0/1", data_valid, req_ready);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_read();
    issue(1'b1, 1'b0, 16'h0102, 16'hBEEF);
    issue(1'b0, 1'b0, 16'h0102, 16'h0);
    idle();
    drain(LAT + 4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wr_rd_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_rd_resp%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_burst();
    fill(16'h0A50, 8, 1'b1);
    issue(1'b0, 1'b1, 16'h0A56, 16'h0);
    idle();
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready_low%0d got %b required 0", i, req_ready); end
      tick();
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready_back got %b required 1", req_ready); end
    drain(LAT + 4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_resp%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    fill(16'h0000, 3, 1'b0);
    issue(1'b0, 1'b0, 16'h0000, 16'h0);
    issue(1'b0, 1'b0, 16'h0002, 16'h0);
    issue(1'b0, 1'b0, 16'h0004, 16'h0);
    idle();
    drain(LAT + 4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_resp%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_read_during_burst();
    fill(16'h0B00, 8, 1'b0);
    fill(16'h0C02, 1, 1'b0);
    issue(1'b0, 1'b1, 16'h0B0A, 16'h0);
    issue(1'b0, 1'b0, 16'h0C03, 16'h0);
    idle();
    drain(LAT + 10);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rdb_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rdb_resp%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int op;
    logic [15:0] a;
    fill(16'h2000, 32, 1'b0);
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 9));
      a  = 16'h2000 | 16'($urandom_range(0, 63));
      if (op < 4)      issue(1'b1, 1'b0, a, 16'($urandom));
      else if (op < 8) issue(1'b0, 1'b0, a, 16'h0);
      else             issue(1'b0, 1'b1, a, 16'h0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
    end
    idle();
    drain(LAT + 10);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_resp%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midburst();
    issue(1'b1, 1'b0, 16'h3000, 16'h5A5A);
    issue(1'b0, 1'b1, 16'h3020, 16'h0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async ready/valid got %b/%b required 1/0", req_ready, data_valid);
    end
    tick();
    rst = 1'b1;
    exp_q.delete(); got_q.delete();
    drain(LAT + 10);
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_resp got %0d responses required 0", got_q.size()); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b required 1", req_ready); end
    got_q.delete();
    issue(1'b0, 1'b0, 16'h3000, 16'h0);
    idle();
    drain(LAT + 4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_readback_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_readback%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef MEM_RESP_COUNT_EN
  task automatic test_resp_count();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (resp_count !== 16'd0) begin n_fail++; $display("FAIL count_reset got %0d required 0", resp_count); end
    issue(1'b0, 1'b1, 16'h0A50, 16'h0);
    issue(1'b0, 1'b0, 16'h0000, 16'h0);
    issue(1'b0, 1'b0, 16'h0002, 16'h0);
    idle();
    drain(LAT + 10);
    n_checks++;
    if (resp_count !== 16'd10) begin n_fail++; $display("FAIL count_total got %0d required 10", resp_count); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (resp_count !== 16'd0) begin n_fail++; $display("FAIL count_cleared got %0d required 0", resp_count); end
    tick();
    rst = 1'b1;
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_back_to_back();
    test_read_during_burst();
    test_random();
    test_reset_midburst();
`ifdef MEM_RESP_COUNT_EN
    test_resp_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
